// File: rtl/e1_rx_crc4_check_if.sv
`default_nettype none
// ============================================================================
// e1_rx_crc4_check_if : byte stream in / SMF check strobe out for CRC-4 checker
// Revision 1.0
// ============================================================================
interface e1_rx_crc4_check_if;
  logic [7:0] in_data;
  logic [4:0] in_ts;
  logic [3:0] in_frame;
  logic       in_valid;
  logic       in_ready;
  logic       in_mf_lock;
  logic       out_valid;
  logic       out_err;
  logic       out_smf;

  modport master (
    output in_data, in_ts, in_frame, in_valid, in_mf_lock,
    input  in_ready, out_valid, out_err, out_smf
  );

  modport slave (
    input  in_data, in_ts, in_frame, in_valid, in_mf_lock,
    output in_ready, out_valid, out_err, out_smf
  );
endinterface
`default_nettype wire

// File: rtl/e1_rx_crc4_check.sv
`default_nettype none
// ============================================================================
// e1_rx_crc4_check : E1 receive CRC-4 per-SMF checker with saturating error count
// Revision 1.0
// ============================================================================
module e1_rx_crc4_check #(
  parameter int CNT_W = 16
) (
  input  wire               clk,
  input  wire               rst,
  e1_rx_crc4_check_if.slave bus,
  input  wire               err_cnt_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             busy_q, busy_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [4:0]       ts_q, ts_d;
  logic [3:0]       frame_q, frame_d;
  logic [3:0]       crc_q, crc_d;
  logic [3:0]       rxc_q, rxc_d;
  logic [3:0]       expect_q, expect_d;
  logic             exp_smf_q, exp_smf_d;
  logic             expect_valid_q, expect_valid_d;
  logic             seen_start_q, seen_start_d;
  logic             out_valid_q, out_valid_d;
  logic             out_err_q, out_err_d;
  logic             out_smf_q, out_smf_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       in_ready_w;
  logic       accept;
  logic       first_bit;
  logic       c_pos;
  logic [1:0] c_ord;
  logic       smf_start;
  logic       smf_end;
  logic       line_bit;
  logic       crc_bit;
  logic [3:0] crc_state;
  logic       fb;
  logic [3:0] crc_next;
  logic [3:0] rxc_next;
  logic       err_inc;

  // A new byte can be taken while the last bit of the current one is on the wire.
  assign in_ready_w = ~busy_q | (bit_cnt_q == 3'd7);
  assign accept     = bus.in_valid & in_ready_w;

  assign first_bit = (bit_cnt_q == 3'd0);
  assign c_pos     = (ts_q == 5'd0) & ~frame_q[0] & first_bit;
  assign c_ord     = frame_q[2:1];
  assign smf_start = (ts_q == 5'd0) & (frame_q[2:0] == 3'd0) & first_bit;
  assign smf_end   = (ts_q == 5'd31) & (frame_q[2:0] == 3'd7) & (bit_cnt_q == 3'd7);
  assign line_bit  = shreg_q[7];
  assign crc_bit   = c_pos ? 1'b0 : line_bit;
  assign crc_state = smf_start ? 4'h0 : crc_q;
  assign fb        = crc_state[3] ^ crc_bit;
  assign crc_next  = {crc_state[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
  assign err_inc   = out_valid_q & out_err_q;

  always_comb begin
    rxc_next = rxc_q;
    if (c_pos) begin
      rxc_next[2'd3 - c_ord] = line_bit;
    end
  end

  always_comb begin
    busy_d         = busy_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    ts_d           = ts_q;
    frame_d        = frame_q;
    crc_d          = crc_q;
    rxc_d          = rxc_q;
    expect_d       = expect_q;
    exp_smf_d      = exp_smf_q;
    expect_valid_d = expect_valid_q;
    seen_start_d   = seen_start_q;
    out_valid_d    = 1'b0;
    out_err_d      = 1'b0;
    out_smf_d      = 1'b0;
    err_cnt_d      = err_cnt_q;

    if (busy_q) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shreg_d   = {shreg_q[6:0], 1'b0};
      if (bit_cnt_q == 3'd7) begin
        busy_d = 1'b0;
      end

      if (!bus.in_mf_lock) begin
        crc_d          = 4'h0;
        rxc_d          = 4'h0;
        expect_valid_d = 1'b0;
        seen_start_d   = 1'b0;
      end else begin
        crc_d = crc_next;
        rxc_d = rxc_next;
        if (smf_start) begin
          seen_start_d = 1'b1;
        end
        // Only an SMF whose start was seen under lock produces a reference CRC.
        if (smf_end) begin
          expect_d       = crc_next;
          exp_smf_d      = frame_q[3];
          expect_valid_d = seen_start_q;
        end
        if (c_pos && (c_ord == 2'd3) && expect_valid_q) begin
          out_valid_d    = 1'b1;
          out_err_d      = (rxc_next != expect_q);
          out_smf_d      = exp_smf_q;
          expect_valid_d = 1'b0;
        end
      end
    end

    if (accept) begin
      busy_d    = 1'b1;
      bit_cnt_d = 3'd0;
      shreg_d   = bus.in_data;
      ts_d      = bus.in_ts;
      frame_d   = bus.in_frame;
    end

    // Clear wins, but an error strobed in the same cycle still counts.
    if (err_cnt_clr) begin
      err_cnt_d = err_inc ? c_cnt_one : '0;
    end else if (err_inc && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + c_cnt_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q         <= 1'b0;
      bit_cnt_q      <= 3'd0;
      shreg_q        <= 8'h00;
      ts_q           <= 5'd0;
      frame_q        <= 4'd0;
      crc_q          <= 4'h0;
      rxc_q          <= 4'h0;
      expect_q       <= 4'h0;
      exp_smf_q      <= 1'b0;
      expect_valid_q <= 1'b0;
      seen_start_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      out_err_q      <= 1'b0;
      out_smf_q      <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      busy_q         <= busy_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      ts_q           <= ts_d;
      frame_q        <= frame_d;
      crc_q          <= crc_d;
      rxc_q          <= rxc_d;
      expect_q       <= expect_d;
      exp_smf_q      <= exp_smf_d;
      expect_valid_q <= expect_valid_d;
      seen_start_q   <= seen_start_d;
      out_valid_q    <= out_valid_d;
      out_err_q      <= out_err_d;
      out_smf_q      <= out_smf_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_smf   = out_smf_q;
  assign err_cnt       = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_e1_rx_crc4_check.sv
`default_nettype none
// ============================================================================
// tb_e1_rx_crc4_check : table-driven SMF stream with strobe scoreboard
// Revision 1.0
// ============================================================================
module tb_e1_rx_crc4_check;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [7:0] p;
    logic [7:0] q;
    logic [3:0] mask;
    logic       exp_strobe;
    logic       exp_err;
  } row_t;

  typedef struct {
    logic err;
    logic smf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             err_cnt_clr;
  logic [CNT_W-1:0] err_cnt;

  e1_rx_crc4_check_if dif ();

  e1_rx_crc4_check #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (dif),
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       sb_q[$];
  row_t       tbl [10];
  logic [7:0] smf_buf [256];
  logic [3:0] prev_crc = 4'h0;
  int         row_idx = 0;
  int         last_acc = 0;
  logic       streaming = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         clr_now_req = 0;
  int         clr_now_done = 0;
  int         clr_c4_req = 0;
  int         clr_c4_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference CRC by augmented long division over the buffered SMF, C bits zeroed.
  function automatic logic [3:0] crc_smf();
    logic [4:0] r;
    logic       bt;
    r = 5'h00;
    for (int i = 0; i < 256; i++) begin
      for (int k = 7; k >= 0; k--) begin
        bt = smf_buf[i][k];
        if (k == 7 && (i % 32) == 0 && ((i / 32) % 2) == 0) bt = 1'b0;
        r = {r[3:0], bt};
        if (r[4]) r = r ^ 5'h13;
      end
    end
    for (int k = 0; k < 4; k++) begin
      r = {r[3:0], 1'b0};
      if (r[4]) r = r ^ 5'h13;
    end
    return r[3:0];
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic [4:0] ts, input logic [3:0] fr,
                           input logic lock);
    int waited;
    waited = 0;
    dif.in_data  = d;
    dif.in_ts    = ts;
    dif.in_frame = fr;
    dif.in_valid = 1'b1;
    @(negedge clk);
    while (!dif.in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!dif.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles want 1", waited);
    end else begin
      if (streaming) check("byte_interval", 32'(cyc - last_acc), 32'd8);
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
    dif.in_mf_lock = lock;
    streaming = 1'b1;
  endtask

  task automatic send_smf(input logic [7:0] p, input logic [7:0] q, input logic [3:0] cbits,
                          input int lo_first, input int lo_last);
    logic       half;
    logic [7:0] b;
    half = row_idx[0];
    for (int i = 0; i < 256; i++) begin
      b = 8'h00;
      if (i == 1) b = p;
      if (i == 5 * 32 + 17) b = q;
      if ((i % 32) == 0 && ((i / 32) % 2) == 0) b[7] = cbits[3 - (i / 64)];
      smf_buf[i] = b;
    end
    for (int i = 0; i < 256; i++) begin
      send_byte(smf_buf[i], 5'(i % 32), {half, 3'(i / 32)}, !(i >= lo_first && i <= lo_last));
    end
    prev_crc = crc_smf();
    row_idx++;
  endtask

  task automatic push_exp(input logic err);
    exp_t e;
    e.err = err;
    e.smf = ~row_idx[0];
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    dif.in_valid = 1'b0;
    streaming    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // err_cnt_clr driver: an immediate one-cycle pulse, or one aligned to the next C4 strobe.
  initial begin : clr_drv
    err_cnt_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_now_req != clr_now_done) begin
        @(posedge clk); #1 err_cnt_clr = 1'b1;
        @(posedge clk); #1 err_cnt_clr = 1'b0;
        clr_now_done++;
      end else if (clr_c4_req != clr_c4_done && dif.in_valid && dif.in_ready &&
                   dif.in_ts == 5'd0 && dif.in_frame[2:0] == 3'd6) begin
        @(posedge clk);
        @(posedge clk); #1 err_cnt_clr = 1'b1;
        @(posedge clk); #1 err_cnt_clr = 1'b0;
        clr_c4_done++;
      end
    end
  end

  initial begin : mon
    int   exp_cnt;
    logic chk;
    logic inc;
    exp_t e;
    exp_cnt = 0;
    chk     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt = 0;
        chk     = 1'b0;
      end else begin
        if (chk) check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        inc = dif.out_valid & dif.out_err;
        if (err_cnt_clr) exp_cnt = inc ? 1 : 0;
        else if (inc && exp_cnt < CNT_MAX) exp_cnt++;
        chk = dif.out_valid;
        if (dif.out_valid) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_strobe: got out_valid=1 smf=%0d want no strobe", dif.out_smf);
          end else begin
            e = sb_q.pop_front();
            check("out_err", 32'(dif.out_err), 32'(e.err));
            check("out_smf", 32'(dif.out_smf), 32'(e.smf));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [3:0] cb;

    tbl[0] = '{8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h00, 4'h0, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h00, 4'h0, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 4'h0, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h00, 4'h8, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 4'h0, 1'b1, 1'b0};
    tbl[6] = '{8'hA5, 8'h3C, 4'h0, 1'b1, 1'b0};
    tbl[7] = '{8'h3C, 8'hC3, 4'h5, 1'b1, 1'b1};
    tbl[8] = '{8'h00, 8'h00, 4'hF, 1'b1, 1'b1};
    tbl[9] = '{8'h00, 8'h00, 4'h0, 1'b1, 1'b0};

    rst            = 1'b1;
    dif.in_valid   = 1'b0;
    dif.in_data    = 8'h00;
    dif.in_ts      = 5'd0;
    dif.in_frame   = 4'd0;
    dif.in_mf_lock = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(dif.in_ready),  32'd1);
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_out_err",   32'(dif.out_err),   32'd0);
    check("rst_out_smf",   32'(dif.out_smf),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),       32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Continuous locked stream; each row's C bits carry the previous SMF's CRC xor mask.
    for (int r = 0; r < 10; r++) begin
      cb = (r == 0) ? 4'h0 : (prev_crc ^ tbl[r].mask);
      if (tbl[r].exp_strobe) push_exp(tbl[r].exp_err);
      send_smf(tbl[r].p, tbl[r].q, cb, -1, -1);
    end
    idle(16);

    clr_now_req++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("err_cnt_after_clr", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;

    // Six errored SMFs; the sixth strobe coincides with err_cnt_clr.
    for (int k = 0; k < 6; k++) begin
      if (k == 5) clr_c4_req++;
      cb = prev_crc ^ 4'h1;
      push_exp(1'b1);
      send_smf(8'(8'h11 * k), 8'h00, cb, -1, -1);
    end

    // Lock lost over frames 3-4 of a first-half SMF.
    send_smf(8'h00, 8'h00, prev_crc, 96, 159);
    send_smf(8'h42, 8'h00, prev_crc, -1, -1);
    push_exp(1'b0);
    send_smf(8'h00, 8'h18, prev_crc, -1, -1);

    // Reset in the middle of a byte while a reference CRC is pending.
    send_byte(8'hFF, 5'd0, 4'd8, 1'b1);
    dif.in_valid = 1'b0;
    streaming    = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready",  32'(dif.in_ready),  32'd1);
    check("midrst_out_valid", 32'(dif.out_valid), 32'd0);
    check("midrst_out_err",   32'(dif.out_err),   32'd0);
    check("midrst_out_smf",   32'(dif.out_smf),   32'd0);
    check("midrst_err_cnt",   32'(err_cnt),       32'd0);
    check("midrst_sb_empty",  32'(sb_q.size()),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    row_idx = 0;
    send_smf(8'h5A, 8'h00, 4'h0, -1, -1);
    push_exp(1'b0);
    send_smf(8'h00, 8'h77, prev_crc, -1, -1);
    idle(16);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
